uparc_execute_mc: RTL
=====================

// Module: uparc_execute_mc
// PURPOSE
//  Parametrised execute stage. Successor to the single-cycle execute stage.
//  Sits between decode and memory stages and evaluates ALU ops and branches.
//  New: configurable data/address widths, an iterative multi-cycle shifter
//  with a back-pressure busy output, and optional branch-likely nullification.
// PARAMETERS
//  DW          32  data/register width (power of 2, >=8)
//  AW          32  address width (AW<=DW)
//  RW           5  register-number width
//  SHIFT_STEP   4  max bits shifted per iteration cycle (1..DW-1)
// PORTS
//  clk             in   1   clock
//  nrst            in   1   async active-low reset
//  i_stall         in   1   combined core stall (fetch/mem/wait)
//  i_nullify       in   1   squash incoming instruction
//  i_pc_p0         in   AW  PC after delay slot (link value)
//  i_pc_p1         in   AW  delay-slot PC (PC-relative base)
//  i_rd_no         in   RW  destination register
//  i_rs_val        in   DW  rs operand
//  i_rt_val        in   DW  rt operand
//  i_imm           in   DW  extended immediate
//  i_op            in   4   0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOR,6 SLT,7 SLTU,8 SLL,9 SRL,10 SRA,11 LUI
//  i_src           in   2   0 rs/rt, 1 rs/imm, 2 pc_p1/imm, 3 rt/rs (shift-variable)
//  i_ovf_en        in   1   signed-overflow trap enable (ADD/SUB)
//  i_jump          in   3   0 NONE,1 J/JR,2 BEQ,3 BNE,4 BLTZ,5 BGEZ,6 BLEZ,7 BGTZ
//  i_link          in   1   write pc_p0 to rd if jump taken
//  i_likely        in   1   branch-likely flavour
//  o_busy          out  1   iterative shift in progress; upstream must hold
//  o_rd_no         out  RW  destination (0 when not-taken jump or nullified)
//  o_result        out  DW  ALU result / link address
//  o_jump_addr     out  AW  branch/jump target (= ALU sum [AW-1:0])
//  o_jump_valid    out  1   branch taken
//  o_overfl_error  out  1   arithmetic overflow
//  o_addr_error    out  1   taken target with addr[1:0]!=0
//  o_squash_ds     out  1   nullify delay slot (branch-likely not taken)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, internal operands 0.
//  - Capture when !i_stall && !o_busy; results registered, latency 1 cycle.
//  - i_nullify at capture: rd_no, jump_valid, ovf/addr errors, squash_ds all 0.
//  - i_stall, not busy: every output holds its value.
//  - FSM IDLE->SHIFT on capture of SLL/SRL/SRA with shamt=b[log2(DW)-1:0]!=0.
//    acc=a, cnt=shamt, o_busy=1 (combinational from state).
//    Each cycle: step=min(cnt,SHIFT_STEP); acc shifted by step; cnt-=step.
//    SRA fills with the original sign. SHIFT iterates even under i_stall.
//    cnt reaches 0 -> o_result=acc, IDLE.
//    Busy cycles = ceil(shamt/SHIFT_STEP); shamt=0 is single-cycle.
//  - During SHIFT, o_rd_no=0 (no writeback); true rd presented on exit.
//  - Arithmetic: DW-bit wrap. Overflow = sign(a)==sign(b')!=sign(sum),
//    where b'=~b+1 for SUB. o_overfl_error = overflow & i_ovf_en.
//    Overflowed results still drive o_result; CU must suppress writeback.
//  - SLT signed, SLTU unsigned, result in bit0. LUI = b<<(DW/2).
//  - Branch compare on rs/rt; target = pc_p1+imm; J/JR target via src.
//  - Link: taken jump with i_link -> o_result=pc_p0 zero-extended to DW.
//  - Not-taken branch: o_rd_no=0, o_jump_valid=0.
//  - o_addr_error = o_jump_valid & |o_jump_addr[1:0].
//  - Reset mid-shift aborts: IDLE, o_busy=0, no result.
// CONFIGURATION
//  UPARC_EXEC_BRANCH_LIKELY_EN
//   defined: i_likely honoured. A likely branch evaluating not-taken
//    asserts o_squash_ds for its 1 result cycle (held under stall).
//   undefined: i_likely ignored, o_squash_ds tied 0. Likely branches behave
//    as ordinary branches.
// TESTING
//  1 ADD rs=32'h7FFFFFFF rt=1 ovf_en=1 -> result 32'h80000000, o_overfl_error=1 next cycle
//  2 SRA a=32'h80000000 shamt=9 STEP=4 -> o_busy 3 cycles, result 32'hFFC00000
//  3 SLL shamt=0 -> no busy, result=a after 1 cycle; mid-shift nrst=0 -> busy=0, outputs 0
//  4 BNE rs=rt=5 link=1 -> jump_valid=0, rd_no=0; BEQ pc_p1=0x100 imm=0x12 -> addr_error=1
//  5 BGEZ rs=-1 likely=1 -> EN: o_squash_ds=1; no EN: o_squash_ds=0
//  6 JAL pc_p0=0x208 rd=31 nullify=1 -> jump_valid=0, rd_no=0; stall 3 cycles -> outputs held

Source files
------------

// File: rtl/uparc_execute_mc.sv
// Parametrised execute stage: single-cycle ALU and branch resolution plus an iterative shifter.
// Optional branch-likely delay-slot squash is enabled by defining UPARC_EXEC_BRANCH_LIKELY_EN.
module uparc_execute_mc #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int RW         = 5,
    parameter int SHIFT_STEP = 4
)(
    input  logic          clk,
    input  logic          nrst,
    input  logic          i_stall,
    input  logic          i_nullify,
    input  logic [AW-1:0] i_pc_p0,
    input  logic [AW-1:0] i_pc_p1,
    input  logic [RW-1:0] i_rd_no,
    input  logic [DW-1:0] i_rs_val,
    input  logic [DW-1:0] i_rt_val,
    input  logic [DW-1:0] i_imm,
    input  logic [3:0]    i_op,
    input  logic [1:0]    i_src,
    input  logic          i_ovf_en,
    input  logic [2:0]    i_jump,
    input  logic          i_link,
    input  logic          i_likely,
    output logic          o_busy,
    output logic [RW-1:0] o_rd_no,
    output logic [DW-1:0] o_result,
    output logic [AW-1:0] o_jump_addr,
    output logic          o_jump_valid,
    output logic          o_overfl_error,
    output logic          o_addr_error,
    output logic          o_squash_ds,
    output logic          o_dbg_state
);
    localparam int SW = $clog2(DW);
    localparam logic [SW-1:0] STEP_W = SW'(SHIFT_STEP);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB  = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_NOR  = 4'd5,  OP_SLT = 4'd6,  OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8,  OP_SRL  = 4'd9,  OP_SRA = 4'd10, OP_LUI = 4'd11;

    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;
    state_t r_state, w_state_nxt;

    logic [DW-1:0] w_a, w_b, w_bp, w_sum, w_alu, w_result_cap;
    logic [SW-1:0] w_shamt, w_step;
    logic          w_capture, w_shift_start, w_shift_done, w_taken, w_jv, w_ovf, w_squash;
    logic [RW-1:0] w_rd_cap;
    logic [DW-1:0] w_acc_nxt;

    logic [DW-1:0] r_acc, r_result;
    logic [SW-1:0] r_cnt;
    logic          r_left, r_sra;
    logic [RW-1:0] r_rd_pend, r_rd_no;
    logic [AW-1:0] r_jump_addr;
    logic          r_jump_valid, r_ovf, r_addr_err, r_squash;

    // Handshake: an instruction is taken on a rising clk edge when !i_stall && !o_busy;
    // upstream must hold its inputs while either is high.
    assign w_capture = !i_stall && (r_state == S_IDLE);

    always_comb begin
        w_a = i_rs_val;
        w_b = i_rt_val;
        case (i_src)
            2'd1:    begin w_a = i_rs_val;      w_b = i_imm;    end
            2'd2:    begin w_a = DW'(i_pc_p1);  w_b = i_imm;    end
            2'd3:    begin w_a = i_rt_val;      w_b = i_rs_val; end
            default: begin w_a = i_rs_val;      w_b = i_rt_val; end
        endcase
    end

    assign w_shamt = w_b[SW-1:0];
    assign w_bp    = (i_op == OP_SUB) ? (~w_b + DW'(1)) : w_b;
    assign w_sum   = w_a + w_bp;
    assign w_ovf   = ((i_op == OP_ADD) || (i_op == OP_SUB))
                   && (w_a[DW-1] == w_bp[DW-1]) && (w_sum[DW-1] != w_a[DW-1]);

    always_comb begin
        w_alu = '0;
        case (i_op)
            OP_ADD, OP_SUB: w_alu = w_sum;
            OP_AND:  w_alu = w_a & w_b;
            OP_OR:   w_alu = w_a | w_b;
            OP_XOR:  w_alu = w_a ^ w_b;
            OP_NOR:  w_alu = ~(w_a | w_b);
            OP_SLT:  w_alu = DW'($signed(w_a) < $signed(w_b));
            OP_SLTU: w_alu = DW'(w_a < w_b);
            OP_SLL:  w_alu = w_a << w_shamt;
            OP_SRL:  w_alu = w_a >> w_shamt;
            OP_SRA:  w_alu = $unsigned($signed(w_a) >>> w_shamt);
            OP_LUI:  w_alu = w_b << (DW / 2);
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (i_jump)
            3'd1: w_taken = 1'b1;
            3'd2: w_taken = (i_rs_val == i_rt_val);
            3'd3: w_taken = (i_rs_val != i_rt_val);
            3'd4: w_taken = i_rs_val[DW-1];
            3'd5: w_taken = !i_rs_val[DW-1];
            3'd6: w_taken = i_rs_val[DW-1] || (i_rs_val == '0);
            3'd7: w_taken = !i_rs_val[DW-1] && (i_rs_val != '0);
            default: w_taken = 1'b0;
        endcase
    end

    assign w_jv         = w_taken && !i_nullify;
    assign w_result_cap = (w_taken && i_link) ? DW'(i_pc_p0) : w_alu;
    assign w_rd_cap     = (i_nullify || ((i_jump != 3'd0) && !w_taken)) ? '0 : i_rd_no;

`ifdef UPARC_EXEC_BRANCH_LIKELY_EN
    assign w_squash = i_likely && (i_jump != 3'd0) && !w_taken && !i_nullify;
`else
    logic w_unused_likely;
    assign w_unused_likely = i_likely;
    assign w_squash        = 1'b0;
`endif

    assign w_shift_start = w_capture && (i_op inside {OP_SLL, OP_SRL, OP_SRA}) && (w_shamt != '0);

    // Each iteration moves at most STEP_W bits; the sign bit of r_acc is the original sign for SRA.
    assign w_step       = (r_cnt > STEP_W) ? STEP_W : r_cnt;
    assign w_shift_done = (r_cnt <= STEP_W);
    assign w_acc_nxt    = r_left ? (r_acc << w_step)
                        : (r_sra ? $unsigned($signed(r_acc) >>> w_step) : (r_acc >> w_step));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_shift_start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_shift_done)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_left       <= 1'b0;
            r_sra        <= 1'b0;
            r_rd_pend    <= '0;
            r_rd_no      <= '0;
            r_result     <= '0;
            r_jump_addr  <= '0;
            r_jump_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_addr_err   <= 1'b0;
            r_squash     <= 1'b0;
        end else if (w_capture) begin
            r_jump_addr  <= w_sum[AW-1:0];
            r_jump_valid <= w_jv;
            r_ovf        <= w_ovf && i_ovf_en && !i_nullify;
            r_addr_err   <= w_jv && (w_sum[1:0] != 2'b00);
            r_squash     <= w_squash;
            if (w_shift_start) begin
                // Destination is withheld until the iterative result is ready.
                r_rd_no   <= '0;
                r_rd_pend <= w_rd_cap;
                r_acc     <= w_a;
                r_cnt     <= w_shamt;
                r_left    <= (i_op == OP_SLL);
                r_sra     <= (i_op == OP_SRA);
            end else begin
                r_rd_no  <= w_rd_cap;
                r_result <= w_result_cap;
            end
        end else if (r_state == S_SHIFT) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - w_step;
            if (w_shift_done) begin
                r_result <= w_acc_nxt;
                r_rd_no  <= r_rd_pend;
            end
        end
    end

    assign o_busy         = (r_state == S_SHIFT);
    assign o_dbg_state    = r_state;
    assign o_rd_no        = r_rd_no;
    assign o_result       = r_result;
    assign o_jump_addr    = r_jump_addr;
    assign o_jump_valid   = r_jump_valid;
    assign o_overfl_error = r_ovf;
    assign o_addr_error   = r_addr_err;
    assign o_squash_ds    = r_squash;
endmodule
